rv32_inst_enc: RTL and testbench

Pipelined RV32I instruction encoder, the inverse of the immediate generator: it takes decoded fields (format, opcode, registers, funct bits, full 32-bit immediate) and scatters the immediate back into the R/I/S/B/U/J bit layout. The result is a 32-bit instruction word paired with a sequential instruction-memory write address. It sits between the debug/boot loader and the instruction memory write port, and lets test programs be assembled in hardware.

---
 rtl/rv32_inst_enc.sv | 152 +++++++++++++++
 tb/tb_rv32_inst_enc.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_inst_enc.sv
// ---------------------------------------------------------------------------
// rv32_inst_enc
//   Pipelined RV32I instruction encoder. It takes a decoded field bundle and
//   scatters the immediate into the R/I/S/B/U/J layout. Each encoded word is
//   paired with a sequential instruction-memory write address. There is one
//   output register stage, with a valid/ready handshake on both sides.
//
//   Optional feature macro: RV32_ENC_RANGECHK_EN
//     When defined, an out-of-range or misaligned immediate is flagged as an
//     error, in the same way as an illegal fmt.
//     When undefined, only an illegal fmt is flagged. Immediates are
//     truncated to the bits that the format carries.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   input bundle handshake
//   fmt                 0=R 1=I 2=S 3=B 4=U 5=J, 6-7 illegal
//   opcode, rd, rs1, rs2, funct3, funct7, imm   decoded fields
//   addr_load/addr_val  reload the address counter (wins over the increment)
//   out_valid/out_ready output handshake
//   out_inst, out_addr  encoded word and its write address
//   out_err             word is an error NOP
//   err_cnt             saturating count of emitted error words
// ---------------------------------------------------------------------------
module rv32_inst_enc #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    input  logic        addr_load,
    input  logic [31:0] addr_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic [15:0] err_cnt
);
    localparam logic [2:0]  FMT_R = 3'd0;
    localparam logic [2:0]  FMT_I = 3'd1;
    localparam logic [2:0]  FMT_S = 3'd2;
    localparam logic [2:0]  FMT_B = 3'd3;
    localparam logic [2:0]  FMT_U = 3'd4;
    localparam logic [2:0]  FMT_J = 3'd5;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        r_out_valid;
    logic [31:0] r_out_inst;
    logic [31:0] r_out_addr;
    logic        r_out_err;
    logic [15:0] r_err_cnt;
    logic [31:0] r_addr_q;

    logic [31:0] w_enc;
    logic        w_fmt_bad;
    logic        w_range_bad;
    logic        w_err;
    logic [31:0] w_inst;
    logic [31:0] w_base;
    logic        w_xfer;

    // The output register can take a new word when it is empty or being drained.
    assign in_ready = !r_out_valid || out_ready;
    assign w_xfer   = in_valid && in_ready;

    always_comb begin
        w_enc     = 32'h0;
        w_fmt_bad = 1'b0;
        case (fmt)
            FMT_R:   w_enc = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I:   w_enc = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S:   w_enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B:   w_enc = {imm[12], imm[10:5], rs2, rs1, funct3,
                              imm[4:1], imm[11], opcode};
            FMT_U:   w_enc = {imm[31:12], rd, opcode};
            FMT_J:   w_enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: w_fmt_bad = 1'b1;
        endcase
    end

`ifdef RV32_ENC_RANGECHK_EN
    // A value fits an N-bit signed field when every bit from N-1 upward
    // matches the sign bit.
    logic w_fits12;
    logic w_fits13;
    logic w_fits21;
    assign w_fits12 = (&imm[31:11]) || !(|imm[31:11]);
    assign w_fits13 = (&imm[31:12]) || !(|imm[31:12]);
    assign w_fits21 = (&imm[31:20]) || !(|imm[31:20]);

    always_comb begin
        w_range_bad = 1'b0;
        case (fmt)
            FMT_I, FMT_S: w_range_bad = !w_fits12;
            FMT_B:        w_range_bad = !w_fits13 || imm[0];
            FMT_J:        w_range_bad = !w_fits21 || imm[0];
            FMT_U:        w_range_bad = |imm[11:0];
            default:      w_range_bad = 1'b0;
        endcase
    end
`else
    assign w_range_bad = 1'b0;
`endif

    assign w_err  = w_fmt_bad || w_range_bad;
    assign w_inst = w_err ? NOP : w_enc;
    // A load in the same cycle as a transfer addresses the word being transferred.
    assign w_base = addr_load ? addr_val : r_addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_inst  <= 32'h0;
            r_out_addr  <= 32'h0;
            r_out_err   <= 1'b0;
            r_err_cnt   <= 16'h0;
            r_addr_q    <= BASE_ADDR;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_inst  <= w_inst;
                r_out_addr  <= w_base;
                r_out_err   <= w_err;
                r_addr_q    <= w_base + 32'd4;
                if (w_err && (r_err_cnt != 16'hFFFF))
                    r_err_cnt <= r_err_cnt + 16'd1;
            end else begin
                if (out_ready)
                    r_out_valid <= 1'b0;
                if (addr_load)
                    r_addr_q <= addr_val;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_inst  = r_out_inst;
    assign out_addr  = r_out_addr;
    assign out_err   = r_out_err;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_rv32_inst_enc.sv
// ---------------------------------------------------------------------------
// tb_rv32_inst_enc
//   Scoreboard bench for rv32_inst_enc. When the driver sees that a bundle
//   will transfer, it pushes the expected word into a queue. The expected
//   word comes from an arithmetic reference model. A monitor pops the queue
//   and compares each word the DUT hands over on out_valid && out_ready.
// ---------------------------------------------------------------------------
module tb_rv32_inst_enc;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  fmt = 3'd0;
    logic [6:0]  opcode = 7'd0;
    logic [4:0]  rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [6:0]  funct7 = 7'd0;
    logic [31:0] imm = 32'd0;
    logic        addr_load = 1'b0;
    logic [31:0] addr_val = 32'd0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        out_err;
    logic [15:0] err_cnt;

    rv32_inst_enc #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .addr_load(addr_load), .addr_val(addr_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_addr = BASE;
    int          m_errs = 0;
    int          total = 0;
    int          bad = 0;
    bit          force_lo = 1'b0;
    bit          rand_rdy = 1'b0;

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    // Reference encoder: pure shift/mask arithmetic on the field values.
    function automatic logic [32:0] model(input logic [2:0] f, input logic [6:0] op,
                                          input logic [4:0] d, input logic [4:0] s1,
                                          input logic [4:0] s2, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [31:0] im);
        logic [31:0] w, o, r_d, r1, r2, q3, q7;
        int          si;
        bit          e;
        o = 32'(op); r_d = 32'(d); r1 = 32'(s1); r2 = 32'(s2); q3 = 32'(f3); q7 = 32'(f7);
        si = int'($signed(im));
        e = 1'b0;
        w = 32'h0;
        case (f)
            3'd0: w = (q7 << 25) | (r2 << 20) | (r1 << 15) | (q3 << 12) | (r_d << 7) | o;
            3'd1: w = ((im & 32'hFFF) << 20) | (r1 << 15) | (q3 << 12) | (r_d << 7) | o;
            3'd2: w = (((im >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (q3 << 12)
                      | ((im & 32'h1F) << 7) | o;
            3'd3: w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (r2 << 20)
                      | (r1 << 15) | (q3 << 12) | (((im >> 1) & 32'hF) << 8)
                      | (((im >> 11) & 32'h1) << 7) | o;
            3'd4: w = (im & 32'hFFFF_F000) | (r_d << 7) | o;
            3'd5: w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                      | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12)
                      | (r_d << 7) | o;
            default: e = 1'b1;
        endcase
`ifdef RV32_ENC_RANGECHK_EN
        case (f)
            3'd1, 3'd2: if (si < -2048 || si > 2047) e = 1'b1;
            3'd3: if (si < -4096 || si > 4094 || (im % 2) != 0) e = 1'b1;
            3'd5: if (si < -(1 << 20) || si > (1 << 20) - 2 || (im % 2) != 0) e = 1'b1;
            3'd4: if ((im % 4096) != 0) e = 1'b1;
            default: ;
        endcase
`endif
        if (e) w = 32'h0000_0013;
        return {e, w};
    endfunction

    // Call just after a rising edge. Holds the bundle until it is accepted,
    // then returns just after the accepting edge. The waits output counts
    // stalled cycles.
    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] im,
                        input logic ld, input logic [31:0] lv, output int waits);
        logic [32:0] r;
        logic [31:0] a;
        bit          ok;
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7;
        imm = im; addr_load = ld; addr_val = lv; in_valid = 1'b1;
        waits = 0;
        ok = 1'b0;
        while (!ok && waits < 100) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else waits++;
        end
        if (!ok) begin
            chk("in_ready_timeout", 128'(in_ready), 128'(1));
        end else begin
            r = model(f, op, d, s1, s2, f3, f7, im);
            a = ld ? lv : m_addr;
            m_addr = a + 32'd4;
            if (r[32] && m_errs < 65535) m_errs++;
            sb.push_back('{inst: r[31:0], addr: a, err: r[32], cnt: 16'(m_errs)});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        addr_load = 1'b0;
    endtask

    // Output-ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            out_ready = force_lo ? 1'b0 : (rand_rdy ? ($urandom_range(3) != 0) : 1'b1);
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", {out_inst, out_addr}, 128'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("word", {out_inst, out_addr, out_err, err_cnt},
                    {e.inst, e.addr, e.err, e.cnt});
            end
        end
    end

    initial begin
        int w;
        int bnd[12];
        logic [95:0] cap;
        bnd = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                (1 << 20) - 2, (1 << 20), -(1 << 20), 32'h1234_5000};

        // Reset state
        #3;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_outputs", {out_inst, out_addr, out_err, err_cnt}, 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // First I word
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'd0, w);

        // Back-to-back S, B, J, U with no bubbles
        send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0, 32'd0, w);
        chk("b2b_s_wait", 128'(w), 128'(0));
        send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4, 1'b0, 32'd0, w);
        chk("b2b_b_wait", 128'(w), 128'(0));
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b0, 32'd0, w);
        chk("b2b_j_wait", 128'(w), 128'(0));
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b0, 32'd0, w);
        chk("b2b_u_wait", 128'(w), 128'(0));
        repeat (3) @(posedge clk);
        #1;

        // Stall: output held, in_ready low, then drain in order
        force_lo = 1'b1;
        @(posedge clk); #1;
        send(3'd0, 7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'd0, 1'b0, 32'd0, w);
        fork
            send(3'd1, 7'h13, 5'd6, 5'd7, 5'd0, 3'd1, 7'd0, 32'd99, 1'b0, 32'd0, w);
            begin
                @(negedge clk);
                cap = {out_inst, out_addr, 31'd0, out_valid};
                chk("stall_valid", 128'(out_valid), 128'(1));
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", 128'(in_ready), 128'(0));
                    chk("stall_hold", {out_inst, out_addr, 31'd0, out_valid}, cap);
                end
                force_lo = 1'b0;
            end
        join

        // Boundary immediate, illegal fmt, address wrap
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'd0, w);
        send(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, 32'd0, w);
        send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b1, 32'hFFFF_FFFC, w);
        send(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0, 32'd0, w);
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset while a word is held
        force_lo = 1'b1;
        @(posedge clk); #1;
        send(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0, 32'd0, w);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_valid", 128'(out_valid), 128'(0));
        chk("rst_async_state", {out_addr, err_cnt}, 128'(0));
        sb.delete();
        m_addr = BASE;
        m_errs = 0;
        force_lo = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        send(3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 1'b0, 32'd0, w);

        // Randomized traffic with random back-pressure and occasional loads
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] im;
            case ($urandom_range(3))
                0: im = $urandom;
                1: im = 32'($urandom_range(8191)) - 32'd4096;
                2: im = 32'(bnd[$urandom_range(11)]);
                default: im = $urandom & 32'hFFFF_F000;
            endcase
            send(3'($urandom_range(7)), 7'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom), 3'($urandom), 7'($urandom), im,
                 ($urandom_range(15) == 0), $urandom, w);
        end

        // Drain
        rand_rdy = 1'b0;
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 128'(sb.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
